// File: rtl/rc6_pkg.sv
// Shared constants and types for the RC6 round-key store.
package rc6_pkg;

  localparam int RC6_WORD_W = 32;
  localparam int RC6_ROUNDS = 20;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } key_state_e;

  // S[] holds two whitening pairs plus one pair per round.
  function automatic int depth_f(input int rounds);
    return 2 * rounds + 4;
  endfunction

endpackage

// File: rtl/rc6_key_ram.sv
// Key table storage: one synchronous write port, two asynchronous read ports.
// Contents are never reset; the owner tracks which entries are valid.
module rc6_key_ram
  import rc6_pkg::*;
#(
  parameter int WORD_W = RC6_WORD_W,
  parameter int DEPTH  = depth_f(RC6_ROUNDS),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WORD_W-1:0] rd_data_a,
  output logic [WORD_W-1:0] rd_data_b
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Addresses past the table (possible for rejected indices) read as zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (int'(rd_addr_a) < DEPTH) begin
      rd_data_a = mem_q[rd_addr_a];
    end
    if (int'(rd_addr_b) < DEPTH) begin
      rd_data_b = mem_q[rd_addr_b];
    end
  end

endmodule

// File: rtl/rc6_key_store.sv
// Runtime-loadable RC6 round-key table; reads return S[2i],S[2i+1] one cycle after rd_req.
// Loads stall (load_ready=0) once full or during clr; reads are never stalled, bad ones get rd_err.
module rc6_key_store
  import rc6_pkg::*;
#(
  parameter int WORD_W = RC6_WORD_W,
  parameter int ROUNDS = RC6_ROUNDS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr,
  input  logic                               load_valid,
  output logic                               load_ready,
  input  logic [WORD_W-1:0]                  load_data,
  output logic                               keys_ready,
  input  logic                               rd_req,
  input  logic [$clog2(ROUNDS+2)-1:0]        rd_idx,
  output logic                               rd_valid,
  output logic                               rd_err,
  output logic [WORD_W-1:0]                  rd_key_a,
  output logic [WORD_W-1:0]                  rd_key_b
);

  localparam int DEPTH  = depth_f(ROUNDS);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int IDX_W  = $clog2(ROUNDS + 2);
  // wr_ptr counts held words, so it must be able to reach DEPTH itself.
  localparam int PTR_W  = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   IDX_LAST = (IDX_W + 1)'(ROUNDS + 1);

  key_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [WORD_W-1:0] rd_key_a_q, rd_key_a_d;
  logic [WORD_W-1:0] rd_key_b_q, rd_key_b_d;

  logic              load_accept;
  logic              idx_ok;
  logic              rd_accept;
  logic [ADDR_W-1:0] ram_rd_addr_a;
  logic [ADDR_W-1:0] ram_rd_addr_b;
  logic [WORD_W-1:0] ram_rd_data_a;
  logic [WORD_W-1:0] ram_rd_data_b;

  assign load_ready  = (state_q != READY) && !clr;
  assign load_accept = load_valid && load_ready;
  assign keys_ready  = (state_q == READY);

  assign idx_ok    = ({1'b0, rd_idx} <= IDX_LAST);
  assign rd_accept = rd_req && (state_q == READY) && !clr && idx_ok;

  assign ram_rd_addr_a = {rd_idx, 1'b0};
  assign ram_rd_addr_b = {rd_idx, 1'b1};

  rc6_key_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en     (load_accept),
    .wr_addr   (wr_ptr_q[ADDR_W-1:0]),
    .wr_data   (load_data),
    .rd_addr_a (ram_rd_addr_a),
    .rd_addr_b (ram_rd_addr_b),
    .rd_data_a (ram_rd_data_a),
    .rd_data_b (ram_rd_data_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    if (clr) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
    end else if (load_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      unique case (state_q)
        EMPTY:   state_d = LOADING;
        LOADING: state_d = (wr_ptr_q == PTR_LAST) ? READY : LOADING;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Key outputs hold between responses; only a request updates them.
  always_comb begin
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && !rd_accept;
    rd_key_a_d = rd_key_a_q;
    rd_key_b_d = rd_key_b_q;
    if (rd_req) begin
      rd_key_a_d = rd_accept ? ram_rd_data_a : '0;
      rd_key_b_d = rd_accept ? ram_rd_data_b : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_key_a_q <= '0;
      rd_key_b_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_key_a_q <= rd_key_a_d;
      rd_key_b_q <= rd_key_b_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_key_a = rd_key_a_q;
  assign rd_key_b = rd_key_b_q;

  a_err_qualified: assert property (@(posedge clk) disable iff (!rst_n)
    rd_err_q |-> rd_valid_q);

  a_ready_means_full: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == READY) |-> (wr_ptr_q == PTR_W'(DEPTH)));

  a_rejected_keys_zero: assert property (@(posedge clk) disable iff (!rst_n)
    rd_err_q |-> (rd_key_a_q == '0 && rd_key_b_q == '0));

endmodule

// File: tb/tb_rc6_key_store.sv
// Bench for rc6_key_store: directed corner sequences, a read-vector table, and random traffic vs a word-count model.
module tb_rc6_key_store;
  import rc6_pkg::*;

  localparam int R     = 20;
  localparam int DEPTH = 2 * R + 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        keys_ready;
  logic        rd_req;
  logic [4:0]  rd_idx;
  logic        rd_valid;
  logic        rd_err;
  logic [31:0] rd_key_a;
  logic [31:0] rd_key_b;

  always #5 clk = ~clk;

  rc6_key_store #(.WORD_W(32), .ROUNDS(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .keys_ready (keys_ready),
    .rd_req     (rd_req),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .rd_key_a   (rd_key_a),
    .rd_key_b   (rd_key_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: a list of loaded words and the last expected response.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt = 0;
  logic        e_valid = 1'b0;
  logic        e_err = 1'b0;
  logic [31:0] e_a = '0;
  logic [31:0] e_b = '0;

  typedef struct {
    int          idx;
    logic        exp_err;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } rd_vec_t;

  rd_vec_t vec [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit full;
    full = (m_cnt == DEPTH);
    if (rd_req) begin
      e_valid = 1'b1;
      if (!clr && full && int'(rd_idx) <= R + 1) begin
        e_err = 1'b0;
        e_a   = m_mem[2 * int'(rd_idx)];
        e_b   = m_mem[2 * int'(rd_idx) + 1];
      end else begin
        e_err = 1'b1;
        e_a   = '0;
        e_b   = '0;
      end
    end else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
    end
    if (clr) begin
      m_cnt = 0;
    end else if (load_valid && !full) begin
      m_mem[m_cnt] = load_data;
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_a     = '0;
    e_b     = '0;
  endtask

  // Called 1ns after an edge with inputs already driven; returns 1ns after the next edge.
  task automatic tick();
    #1;
    chk("load_ready", {31'b0, load_ready}, {31'b0, (m_cnt != DEPTH) && !clr});
    model_edge();
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_valid});
    chk("rd_err", {31'b0, rd_err}, {31'b0, e_err});
    chk("rd_key_a", rd_key_a, e_a);
    chk("rd_key_b", rd_key_b, e_b);
    chk("keys_ready", {31'b0, keys_ready}, {31'b0, m_cnt == DEPTH});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_load_ready"}, {31'b0, load_ready}, 32'd1);
    chk({tag, "_keys_ready"}, {31'b0, keys_ready}, 32'd0);
    chk({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
    chk({tag, "_rd_err"}, {31'b0, rd_err}, 32'd0);
    chk({tag, "_rd_key_a"}, rd_key_a, 32'd0);
    chk({tag, "_rd_key_b"}, rd_key_b, 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic load_words(input logic [31:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      load_valid = 1'b1;
      load_data  = base + k;
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic read_one(input int idx);
    rd_req = 1'b1;
    rd_idx = 5'(idx);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    vec[0] = '{0,  1'b0, 32'h1000_0000, 32'h1000_0001};
    vec[1] = '{21, 1'b0, 32'h1000_002A, 32'h1000_002B};
    vec[2] = '{22, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vec[3] = '{1,  1'b0, 32'h1000_0002, 32'h1000_0003};
    vec[4] = '{31, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vec[5] = '{10, 1'b0, 32'h1000_0014, 32'h1000_0015};

    clr        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    rd_req     = 1'b0;
    rd_idx     = '0;
    rst_n      = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full load; a read on the final word's cycle must be rejected.
    for (int k = 0; k < DEPTH; k++) begin
      load_valid = 1'b1;
      load_data  = 32'h1000_0000 + k;
      if (k == DEPTH - 1) begin
        rd_req = 1'b1;
        rd_idx = '0;
      end
      tick();
      if (k == DEPTH - 2) chk("keys_ready_before_last", {31'b0, keys_ready}, 32'd0);
    end
    load_valid = 1'b0;
    rd_req     = 1'b0;
    chk("keys_ready_after_last", {31'b0, keys_ready}, 32'd1);
    chk("load_ready_when_full", {31'b0, load_ready}, 32'd0);
    chk("rd_err_same_cycle_as_last", {31'b0, rd_err}, 32'd1);

    read_one(0);
    chk("first_read_err", {31'b0, rd_err}, 32'd0);
    chk("first_read_a", rd_key_a, 32'h1000_0000);
    chk("first_read_b", rd_key_b, 32'h1000_0001);

    // Writes while full are ignored.
    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    tick();
    load_valid = 1'b0;
    read_one(0);
    chk("no_overwrite_a", rd_key_a, 32'h1000_0000);

    // Back-to-back table reads, no idle cycles between requests.
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1;
      rd_idx = 5'(vec[i].idx);
      tick();
      chk("tbl_valid", {31'b0, rd_valid}, 32'd1);
      chk("tbl_err", {31'b0, rd_err}, {31'b0, vec[i].exp_err});
      chk("tbl_a", rd_key_a, vec[i].exp_a);
      chk("tbl_b", rd_key_b, vec[i].exp_b);
    end
    rd_req = 1'b0;
    tick();
    chk("key_hold_a", rd_key_a, 32'h1000_0014);

    // Partial load: reads rejected, remaining words complete the table exactly.
    do_clr();
    load_words(32'h3000_0000, 0, 9);
    read_one(0);
    chk("partial_rd_err", {31'b0, rd_err}, 32'd1);
    chk("partial_load_ready", {31'b0, load_ready}, 32'd1);
    load_words(32'h3000_0000, 10, DEPTH - 2);
    chk("partial_not_full", {31'b0, keys_ready}, 32'd0);
    load_words(32'h3000_0000, DEPTH - 1, DEPTH - 1);
    chk("partial_full", {31'b0, keys_ready}, 32'd1);
    read_one(21);
    chk("partial_a", rd_key_a, 32'h3000_002A);
    chk("partial_b", rd_key_b, 32'h3000_002B);

    // clr beats a same-cycle load and read.
    do_clr();
    load_words(32'h5555_0000, 0, 19);
    clr        = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'hBAD0_0BAD;
    rd_req     = 1'b1;
    rd_idx     = '0;
    #1;
    chk("clr_load_ready", {31'b0, load_ready}, 32'd0);
    tick();
    chk("clr_rd_err", {31'b0, rd_err}, 32'd1);
    clr        = 1'b0;
    load_valid = 1'b0;
    rd_req     = 1'b0;
    load_words(32'h2000_0000, 0, DEPTH - 1);
    read_one(5);
    chk("reload_a", rd_key_a, 32'h2000_000A);
    chk("reload_b", rd_key_b, 32'h2000_000B);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      clr        = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = $urandom;
      rd_req     = $urandom_range(0, 1) == 1;
      rd_idx     = 5'($urandom_range(0, 31));
      tick();
    end
    clr        = 1'b0;
    load_valid = 1'b0;
    rd_req     = 1'b0;

    // Async reset with a response still in flight.
    do_clr();
    load_words(32'h4000_0000, 0, DEPTH - 1);
    read_one(1);
    chk("rst_seq_resp1_valid", {31'b0, rd_valid}, 32'd1);
    chk("rst_seq_resp1_a", rd_key_a, 32'h4000_0002);
    read_one(2);
    chk("rst_seq_resp2_valid", {31'b0, rd_valid}, 32'd1);
    chk("rst_seq_resp2_a", rd_key_a, 32'h4000_0004);
    rd_req = 1'b1;
    rd_idx = 5'd3;
    #6 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    chk("no_resp_idx3", {31'b0, rd_valid}, 32'd0);
    rd_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_vals("post_rst");
    tick();
    read_one(0);
    chk("post_rst_read_rejected", {31'b0, rd_err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
